lsu_unaligned: RTL
==================

Name: lsu_unaligned

Overview:
- Load/store sequencer directly upstream of the 2 KB byte-addressed unaligned block RAM (4 x 512x8 byte lanes, 1-cycle registered read, 32-bit write at any byte address).
- Accepts one CPU memory request at a time and drives the RAM port.
- Byte and halfword stores are performed as read-modify-write, because the RAM always writes 4 bytes.
- Returns loads sign- or zero-extended.

Parameters:
- ADDR_WIDTH, 11, byte address width; must match the RAM address width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address, any alignment
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_signed  in  1  loads: sign-extend; ignored for stores
- req_wdata  in  32  store data, least-significant bytes used for byte/half
- rsp_valid  out  1  one-cycle load-data strobe; no backpressure
- rsp_rdata  out  32  formatted load data
- ram_raddr  out  ADDR_WIDTH  RAM read byte address
- ram_waddr  out  ADDR_WIDTH  RAM write byte address
- ram_wdata  out  32  RAM write data, byte 0 at the addressed byte
- ram_wren  out  1  RAM write enable
- ram_rdata  in  32  RAM read data; valid 1 cycle after ram_raddr is presented

Behaviour:
- Reset is synchronous and active-high, and applies on clock.
  - While reset is sampled high: state = IDLE, req_ready = 0.
  - All other outputs are 0: rsp_valid, rsp_rdata, ram_raddr, ram_waddr, ram_wdata, ram_wren.
  - The first cycle after reset deasserts: req_ready = 1.
- Registered outputs: all outputs are registers except req_ready. req_ready = (state == IDLE) && !reset.
- States: IDLE, RD, LDATA, MERGE, WR.
- Accept: req_valid && req_ready at edge T latches write, addr, size, signed and wdata. ram_raddr and ram_waddr take the latched address.
- Transitions out of IDLE on accept:
  - Store, word: go to WR.
  - Store, byte or half: go to RD.
  - Load: go to RD.
- RD (T+1): the RAM samples ram_raddr. Next state: LDATA for a load, MERGE for a store.
- ram_raddr hold rule: ram_raddr must stay unchanged through RD and LDATA/MERGE. The RAM's lane rotation uses the current raddr[1:0] when returning data.
- LDATA (T+2): ram_rdata is valid.
  - rsp_rdata <= formatted value.
  - Byte: ram_rdata[7:0], extended from bit 7 if signed, else zero-extended.
  - Half: ram_rdata[15:0], extended from bit 15 if signed, else zero-extended.
  - Word: ram_rdata passed through.
  - rsp_valid <= 1; next state IDLE.
  - Net effect: rsp_valid is high for exactly cycle T+3, and req_ready is also 1 in T+3.
- MERGE (T+2): ram_wdata <= ram_rdata with the low bytes replaced. Byte replaces [7:0]; half replaces [15:0]. ram_wren <= 1; next state WR.
- WR: ram_wren is high for exactly one cycle.
  - Word store: ram_wdata = latched wdata, ram_wren high in T+1.
  - Sub-word store: ram_wren high in T+3.
  - Next state IDLE; ram_wren <= 0.
- rsp_rdata holds its last value until the next load completes.
- Occupancy: a word store takes 2 cycles; loads and sub-word stores take 3 cycles in flight plus the return to IDLE. One request is outstanding at a time, so no address hazards: a load accepted after a store's WR cycle sees the stored data.
- Address wrap: addresses pass through unchanged. Wrap-around at the top of memory (e.g. a word at 0x7FF) is handled by the RAM modulo its bank depth; the LSU does no range or alignment checks.
- req_valid without acceptance: ignored outside IDLE. The requester holds its request until req_ready.
- Reset mid-operation: the operation is aborted.
  - No write is issued on any edge where reset is sampled.
  - A pending sub-word store never writes.
  - A pending load produces no rsp_valid.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x003; load word, unsigned, at 0x003 → rsp_rdata = 0xDEADBEEF, rsp_valid pulses for one cycle exactly 3 cycles after acceptance.
- Byte store RMW: word 0x11223344 at 0x010; store byte 0xAA at 0x011 → load word 0x010 = 0x1122AA44, and ram_wren pulses once, 3 cycles after acceptance.
- Sign extension: memory byte 0x85 at 0x020.
  - Load byte signed → 0xFFFFFF85.
  - Load byte unsigned → 0x00000085.
  - Half signed at 0x020 with 0x8001 → 0xFFFF8001.
- Top-of-memory wrap: store word 0x01020304 at 0x7FE; load byte at 0x7FF → 0x03; load byte at 0x000 → 0x02.
- Back-to-back: req_valid held high with 3 queued requests (word store, half store, load) → req_ready low while busy, no request lost, ram_wren pulses exactly twice, final load correct.
- Reset mid-RMW: byte store accepted, reset asserted in the RD cycle → ram_wren never pulses, memory unchanged, all outputs 0, req_ready = 1 one cycle after reset drops.

Source files
------------

// File: rtl/lsu_unaligned.sv
// Load/store sequencer in front of the unaligned byte-lane RAM: one request at a time,
// sub-word stores done as read-modify-write, loads returned sign- or zero-extended.
module lsu_unaligned #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_wren,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LDATA,
    MERGE,
    WR
  } state_t;

  state_t state;
  state_t state_next;

  logic        accept;
  logic        word_store;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] op_wdata;
  logic [31:0] load_fmt;
  logic [31:0] merge_data;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  // Sizes 2 and 3 are both full words, so bit 1 alone selects the word path.
  assign word_store = req_write && req_size[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = word_store ? WR : RD;
      RD:      state_next = op_write ? MERGE : LDATA;
      LDATA:   state_next = IDLE;
      MERGE:   state_next = WR;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM has already rotated the addressed byte into lane 0, so both the load
  // formatter and the store merge only ever touch the low bytes.
  always_comb begin
    load_fmt   = ram_rdata;
    merge_data = ram_rdata;
    case (op_size)
      2'd0: begin
        load_fmt         = {{24{op_signed & ram_rdata[7]}}, ram_rdata[7:0]};
        merge_data[7:0]  = op_wdata[7:0];
      end
      2'd1: begin
        load_fmt         = {{16{op_signed & ram_rdata[15]}}, ram_rdata[15:0]};
        merge_data[15:0] = op_wdata[15:0];
      end
      default: ;
    endcase
  end

  // ram_raddr only moves on accept, so it stays put through RD and LDATA/MERGE
  // while the RAM uses its low bits to rotate the returned word.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_write  <= 1'b0;
      op_size   <= 2'd0;
      op_signed <= 1'b0;
      op_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_raddr <= '0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      ram_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_write  <= req_write;
            op_size   <= req_size;
            op_signed <= req_signed;
            op_wdata  <= req_wdata;
            ram_raddr <= req_addr;
            ram_waddr <= req_addr;
            if (word_store) begin
              ram_wdata <= req_wdata;
              ram_wren  <= 1'b1;
            end
          end
        end
        LDATA: begin
          rsp_rdata <= load_fmt;
          rsp_valid <= 1'b1;
        end
        MERGE: begin
          ram_wdata <= merge_data;
          ram_wren  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
